// File: rtl/sram_mport_ctrl.sv
// Multi-port asynchronous SRAM controller: round-robin arbitration across NCH
// requesters, fixed SETUP / ACCESS / DONE strobe sequence with registered pins.
//
// state  | meaning
// IDLE   | pins released, arbitrating among pending requests
// SETUP  | address, byte lanes and CS/OE (read) or data drive (write) settle
// ACCESS | WAIT+1 cycles of OE (read) or WE (write) asserted
// DONE   | CS still low, write data held after WE rises, ack pulsed
module sram_mport_ctrl #(
    parameter int NCH  = 2,
    parameter int AW   = 18,
    parameter int WAIT = 0
) (
    input  logic              CLK0,
    input  logic              reset_n,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    we,
    input  logic [NCH*AW-1:0] addr,
    input  logic [NCH*2-1:0]  be,
    input  logic [NCH*16-1:0] wdata,
    output logic [15:0]       rdata,
    output logic [NCH-1:0]    ack,
    output logic [AW-1:0]     ADR,
    output logic [15:0]       dq_out,
    output logic              dq_oe,
    input  logic [15:0]       dq_in,
    output logic              RAMCS_n,
    output logic              RAMOE_n,
    output logic              RAMWE_n,
    output logic              RAMUB_n,
    output logic              RAMLB_n
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [2:0]    cnt, cnt_nxt;
    logic [PW-1:0] ptr, cur_ch, gnt_idx;
    logic          gnt_found;
    logic          lat_we;
    logic [1:0]    lat_be;

    logic          sel_we;
    logic [1:0]    sel_be;
    logic [AW-1:0] sel_addr;
    logic [15:0]   sel_wdata;

    logic          op_we;
    logic [1:0]    op_be;
    logic          cs_n_nxt, oe_n_nxt, we_n_nxt, ub_n_nxt, lb_n_nxt, dq_oe_nxt;
    logic [NCH-1:0] ack_nxt;
    int            idx;

    // Search starts just after the last granted channel, wrapping to 0.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = 1; k <= NCH; k++) begin
            idx = (int'(ptr) + k) % NCH;
            if (!gnt_found && req[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = PW'(idx);
            end
        end
    end

    always_comb begin
        sel_we    = we[gnt_idx];
        sel_be    = be[int'(gnt_idx)*2 +: 2];
        sel_addr  = addr[int'(gnt_idx)*AW +: AW];
        sel_wdata = wdata[int'(gnt_idx)*16 +: 16];
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE:   if (gnt_found) state_nxt = SETUP;
            SETUP: begin
                state_nxt = ACCESS;
                cnt_nxt   = 3'(WAIT);
            end
            ACCESS: begin
                if (cnt == 3'd0) state_nxt = DONE;
                else             cnt_nxt   = cnt - 3'd1;
            end
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pins are registered from the next state; during the grant cycle the
    // operation attributes come straight from the winning channel.
    always_comb begin
        op_we     = (state == IDLE) ? sel_we : lat_we;
        op_be     = (state == IDLE) ? sel_be : lat_be;
        cs_n_nxt  = 1'b1;
        oe_n_nxt  = 1'b1;
        we_n_nxt  = 1'b1;
        ub_n_nxt  = 1'b1;
        lb_n_nxt  = 1'b1;
        dq_oe_nxt = 1'b0;
        ack_nxt   = '0;
        if (state_nxt != IDLE) begin
            cs_n_nxt = 1'b0;
            if (op_we) begin
                dq_oe_nxt = 1'b1;
                ub_n_nxt  = ~op_be[1];
                lb_n_nxt  = ~op_be[0];
                we_n_nxt  = !((state_nxt == ACCESS) && (op_be != 2'b00));
            end else begin
                ub_n_nxt = 1'b0;
                lb_n_nxt = 1'b0;
                oe_n_nxt = (state_nxt == DONE);
            end
        end
        if (state_nxt == DONE) ack_nxt = NCH'(1) << cur_ch;
    end

    always_ff @(posedge CLK0) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            ptr     <= PW'(NCH - 1);
            cur_ch  <= '0;
            lat_we  <= 1'b0;
            lat_be  <= 2'b00;
            ADR     <= '0;
            dq_out  <= 16'h0000;
            dq_oe   <= 1'b0;
            rdata   <= 16'h0000;
            ack     <= '0;
            RAMCS_n <= 1'b1;
            RAMOE_n <= 1'b1;
            RAMWE_n <= 1'b1;
            RAMUB_n <= 1'b1;
            RAMLB_n <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            if (state == IDLE && gnt_found) begin
                ptr    <= gnt_idx;
                cur_ch <= gnt_idx;
                lat_we <= sel_we;
                lat_be <= sel_be;
                ADR    <= sel_addr;
                dq_out <= sel_wdata;
            end
            if (state == ACCESS && cnt == 3'd0 && !lat_we) rdata <= dq_in;
            dq_oe   <= dq_oe_nxt;
            ack     <= ack_nxt;
            RAMCS_n <= cs_n_nxt;
            RAMOE_n <= oe_n_nxt;
            RAMWE_n <= we_n_nxt;
            RAMUB_n <= ub_n_nxt;
            RAMLB_n <= lb_n_nxt;
        end
    end

endmodule

// File: tb/tb_sram_mport_ctrl.sv
// Directed bench for sram_mport_ctrl (NCH=4, WAIT=1) with a small behavioural
// SRAM attached to the pins.
module tb_sram_mport_ctrl;

    localparam int NCH = 4;
    localparam int AW  = 18;
    localparam int WT  = 1;

    logic              CLK0 = 1'b0;
    logic              reset_n;
    logic [NCH-1:0]    req;
    logic [NCH-1:0]    we;
    logic [NCH*AW-1:0] addr;
    logic [NCH*2-1:0]  be;
    logic [NCH*16-1:0] wdata;
    logic [15:0]       rdata;
    logic [NCH-1:0]    ack;
    logic [AW-1:0]     ADR;
    logic [15:0]       dq_out, dq_in;
    logic              dq_oe;
    logic              RAMCS_n, RAMOE_n, RAMWE_n, RAMUB_n, RAMLB_n;

    int cmp = 0;
    int err = 0;

    sram_mport_ctrl #(.NCH(NCH), .AW(AW), .WAIT(WT)) dut (
        .CLK0(CLK0), .reset_n(reset_n), .req(req), .we(we), .addr(addr),
        .be(be), .wdata(wdata), .rdata(rdata), .ack(ack), .ADR(ADR),
        .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dq_in), .RAMCS_n(RAMCS_n),
        .RAMOE_n(RAMOE_n), .RAMWE_n(RAMWE_n), .RAMUB_n(RAMUB_n), .RAMLB_n(RAMLB_n)
    );

    always #5 CLK0 = ~CLK0;

    // Behavioural SRAM, 256 words addressed by ADR[7:0].
    logic [15:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    assign dq_in = (!RAMCS_n && !RAMOE_n) ? mem[ADR[7:0]] : 16'h0000;
    always @(posedge CLK0) begin
        if (!RAMCS_n && !RAMWE_n && dq_oe) begin
            if (!RAMUB_n) mem[ADR[7:0]][15:8] <= dq_out[15:8];
            if (!RAMLB_n) mem[ADR[7:0]][7:0]  <= dq_out[7:0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp++;
        assert (obs === exp) else begin
            err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK0);
        #1;
    endtask

    // One transfer on channel ch, started in cycle 0. Optionally changes the
    // channel's addr/wdata in cycle 1. Returns the ack cycle (-1 on timeout).
    task automatic xfer(input int ch, input logic w, input logic [AW-1:0] a,
                        input logic [1:0] b, input logic [15:0] d, input bit mutate,
                        output int ack_cyc, output int we_lo, output logic [15:0] rd,
                        output logic ub, output logic lb,
                        output logic [AW-1:0] adr2, output logic [15:0] dq2);
        we[ch]              = w;
        addr[ch*AW +: AW]   = a;
        be[ch*2 +: 2]       = b;
        wdata[ch*16 +: 16]  = d;
        req[ch]             = 1'b1;
        ack_cyc = -1; we_lo = 0; rd = 16'h0; ub = 1'bx; lb = 1'bx;
        adr2 = '0; dq2 = 16'h0;
        for (int c = 1; c <= 20 && ack_cyc < 0; c++) begin
            step();
            if (!RAMWE_n) we_lo++;
            if (c == 1 && mutate) begin
                addr[ch*AW +: AW]  = 18'h000FF;
                wdata[ch*16 +: 16] = 16'h0000;
            end
            if (c == 2) begin
                ub = RAMUB_n; lb = RAMLB_n; adr2 = ADR; dq2 = dq_out;
            end
            if (ack[ch]) begin
                ack_cyc = c;
                rd      = rdata;
                req[ch] = 1'b0;
            end
        end
        step();
        step();
    endtask

    int          ac, wl;
    logic [15:0] rd, dq2;
    logic        ub, lb;
    logic [AW-1:0] adr2;
    int          ack_ch [5];
    int          ack_t  [5];
    int          n_ack;

    initial begin
        reset_n = 1'b0;
        req = '0; we = '0; addr = '0; be = '0; wdata = '0;
        step(); step();
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_adr", 32'(ADR), 32'h0);
        chk("rst_pins", {27'h0, RAMCS_n, RAMOE_n, RAMWE_n, RAMUB_n, RAMLB_n}, 32'h1F);
        chk("rst_oe_dq", {15'h0, dq_oe, dq_out}, 32'h0);
        reset_n = 1'b1;
        step();

        xfer(0, 1'b1, 18'h00123, 2'b11, 16'hBEEF, 1'b0, ac, wl, rd, ub, lb, adr2, dq2);
        chk("wr_ack_cycle", 32'(ac), 32'd4);
        chk("wr_we_low", 32'(wl), 32'd2);

        xfer(0, 1'b0, 18'h00123, 2'b00, 16'h0, 1'b0, ac, wl, rd, ub, lb, adr2, dq2);
        chk("rd_ack_cycle", 32'(ac), 32'd4);
        chk("rd_data", 32'(rd), 32'hBEEF);
        chk("rd_lanes", {30'h0, ub, lb}, 32'h0);
        chk("rd_no_we", 32'(wl), 32'd0);

        xfer(2, 1'b1, 18'h00123, 2'b01, 16'h1234, 1'b0, ac, wl, rd, ub, lb, adr2, dq2);
        chk("bw_lanes", {30'h0, ub, lb}, 32'h2);
        chk("bw_ack_cycle", 32'(ac), 32'd4);
        xfer(3, 1'b0, 18'h00123, 2'b00, 16'h0, 1'b0, ac, wl, rd, ub, lb, adr2, dq2);
        chk("bw_readback", 32'(rd), 32'hBE34);

        xfer(1, 1'b1, 18'h00123, 2'b00, 16'h0000, 1'b0, ac, wl, rd, ub, lb, adr2, dq2);
        chk("be0_ack_cycle", 32'(ac), 32'd4);
        chk("be0_no_we", 32'(wl), 32'd0);
        xfer(1, 1'b0, 18'h00123, 2'b00, 16'h0, 1'b0, ac, wl, rd, ub, lb, adr2, dq2);
        chk("be0_mem_kept", 32'(rd), 32'hBE34);

        xfer(1, 1'b1, 18'h00045, 2'b11, 16'hA5A5, 1'b1, ac, wl, rd, ub, lb, adr2, dq2);
        chk("latch_adr", 32'(adr2), 32'h00045);
        chk("latch_dq", 32'(dq2), 32'hA5A5);
        xfer(1, 1'b0, 18'h00045, 2'b00, 16'h0, 1'b0, ac, wl, rd, ub, lb, adr2, dq2);
        chk("latch_readback", 32'(rd), 32'hA5A5);
        xfer(1, 1'b0, 18'h000FF, 2'b00, 16'h0, 1'b0, ac, wl, rd, ub, lb, adr2, dq2);
        chk("latch_other_addr", 32'(rd), 32'h0000);

        // Reset during ACCESS of a write, then all four channels held high.
        we[1] = 1'b1; addr[1*AW +: AW] = 18'h000AA; be[3:2] = 2'b11; wdata[31:16] = 16'h5A5A;
        req = 4'b0010;
        step(); step();
        chk("mid_we_low", 32'(RAMWE_n), 32'h0);
        reset_n = 1'b0;
        we = '0;
        req = 4'b1111;
        step();
        chk("mid_we_n", 32'(RAMWE_n), 32'h1);
        chk("mid_dq_oe", 32'(dq_oe), 32'h0);
        chk("mid_cs_n", 32'(RAMCS_n), 32'h1);
        chk("mid_ack", 32'(ack), 32'h0);
        step();
        chk("mid_ack2", 32'(ack), 32'h0);
        reset_n = 1'b1;

        n_ack = 0;
        for (int c = 1; c <= 60 && n_ack < 5; c++) begin
            step();
            if (ack != '0) begin
                ack_t[n_ack] = c;
                ack_ch[n_ack] = 0;
                for (int i = 0; i < NCH; i++) if (ack[i]) ack_ch[n_ack] = i;
                n_ack++;
            end
        end
        chk("rr_count", 32'(n_ack), 32'd5);
        if (n_ack == 5) begin
            chk("rr_first_ack", 32'(ack_t[0]), 32'd4);
            for (int i = 0; i < 5; i++) chk($sformatf("rr_order_%0d", i), 32'(ack_ch[i]), 32'(i % NCH));
            for (int i = 1; i < 5; i++) chk($sformatf("rr_space_%0d", i), 32'(ack_t[i] - ack_t[i-1]), 32'(4 + WT));
        end
        req = '0;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

endmodule

// File: doc/sram_mport_ctrl.md
SRAM_MPORT_CTRL -- requirements
Module: sram_mport_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 2, number of requester channels (1..4).
REQ-002 SHALL have parameter AW, default 18, SRAM word-address width.
REQ-003 SHALL have parameter WAIT, default 0, extra ACCESS cycles per transfer (0..7).
REQ-004 SHALL have port CLK0  in  1  system clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port req  in  NCH  per-channel request, held high until ack.
REQ-007 SHALL have port we  in  NCH  per-channel write (1) / read (0).
REQ-008 SHALL have port addr  in  NCH*AW  per-channel word address; channel i at [i*AW +: AW].
REQ-009 SHALL have port be  in  NCH*2  per-channel byte enables; bit1 upper byte, bit0 lower byte.
REQ-010 SHALL have port wdata  in  NCH*16  per-channel write data.
REQ-011 SHALL have port rdata  out  16  read data, shared by all channels.
REQ-012 SHALL have port ack  out  NCH  one-cycle completion pulse per channel.
REQ-013 SHALL have ports ADR  out  AW, dq_out  out  16, dq_oe  out  1, dq_in  in  16; these drive the SRAM address pins and the bidirectional data pad cell.
REQ-014 SHALL have ports RAMCS_n, RAMOE_n, RAMWE_n, RAMUB_n, RAMLB_n  out  1 each; SRAM strobes, all active-low.

Function
REQ-015 SHALL implement FSM IDLE -> SETUP -> ACCESS (WAIT+1 cycles, counted by a 3-bit counter) -> DONE -> IDLE.
REQ-016 SHALL, in IDLE with any req high, grant one channel round-robin: first requesting index after the last granted, wrapping NCH-1 -> 0.
REQ-017 SHALL latch the granted channel's we, addr, be and wdata at grant; later changes on that channel's inputs SHALL NOT affect the transfer in flight.
REQ-018 SHALL register ADR, dq_out and the strobes so they change only on CLK0 edges.
REQ-019 SHALL assert RAMCS_n=0 during SETUP, ACCESS and DONE.
REQ-020 SHALL, on reads, assert RAMOE_n=0 in SETUP and ACCESS, and drive RAMUB_n=RAMLB_n=0 regardless of be.
REQ-021 SHALL, on writes, assert dq_oe=1 in SETUP, ACCESS and DONE.
REQ-022 SHALL, on writes, assert RAMWE_n=0 during ACCESS only, giving one cycle of data hold after WE rises.
REQ-023 SHALL, on writes, drive RAMUB_n=~be[1] and RAMLB_n=~be[0].
REQ-024 SHALL, when a write has be=2'b00, complete the full sequence and ack it without asserting RAMWE_n.
REQ-025 SHALL capture dq_in into rdata at the last ACCESS edge of a read, and hold rdata until the next read capture.
REQ-026 SHALL pulse ack[g] for exactly the DONE cycle; if req is seen in cycle 0, ack is high in cycle 3+WAIT.
REQ-027 SHALL give a minimum spacing of 4+WAIT cycles between grants.
REQ-028 SHALL use DONE -> IDLE unconditionally; a requester still high in IDLE after its own ack is treated as a new request.
REQ-029 SHALL ignore requests arriving during SETUP, ACCESS or DONE until the next IDLE; requests are never lost while held.
REQ-030 SHALL, with NCH=1, reduce arbitration to a direct grant of channel 0.

Reset
REQ-031 SHALL, while reset_n=0 at a CLK0 edge, force state=IDLE, wait counter=0 and round-robin pointer=NCH-1, so channel 0 has first priority.
REQ-032 SHALL, under reset, drive ack=0, rdata=16'h0000, dq_oe=0, dq_out=0 and ADR=0, and drive RAMCS_n, RAMOE_n, RAMWE_n, RAMUB_n and RAMLB_n all to 1.
REQ-033 SHALL abort any transfer in flight when reset is asserted mid-transfer: no ack is issued, and all strobes are inactive after the reset edge.

Verification
REQ-034 SHALL cover: WAIT=1, ch0 write addr=18'h00123, data=16'hBEEF, be=11 -> RAMWE_n low for 2 cycles, ack[0] in cycle 4; then read of 18'h00123 -> rdata=16'hBEEF during ack[0].
REQ-035 SHALL cover: NCH=4, all req high continuously -> grant order 0,1,2,3,0 with grants spaced 4+WAIT cycles apart.
REQ-036 SHALL cover: byte write be=01, data=16'h1234 over stored 16'hBEEF -> RAMUB_n=1, RAMLB_n=0; readback gives 16'hBE34.
REQ-037 SHALL cover: reset_n=0 during ACCESS of a write -> next cycle RAMWE_n=1, dq_oe=0, no ack; after release, ch0 is granted first.
REQ-038 SHALL cover: ch1 addr/wdata changed the cycle after grant -> SRAM sees the originally latched values.
REQ-039 SHALL cover: write with be=00 -> ack issued, RAMWE_n never low, memory unchanged.
